// File: rtl/ex_muldiv.sv
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : Execute-stage iterative multiply/divide unit with operand
//             forwarding muxes and HI/LO registers. Build option
//             MD_EARLY_OUT_EN lets multiplies stop once the multiplier is spent.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [WIDTH-1:0] rd1_ex,
    input  logic [WIDTH-1:0] rd2_ex,
    input  logic [WIDTH-1:0] alu_result_mem,
    input  logic [WIDTH-1:0] result_wb,
    input  logic             md_start_ex,
    input  logic [2:0]       md_op_ex,
    output logic [WIDTH-1:0] src_a_ex,
    output logic [WIDTH-1:0] src_b_ex,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             md_busy,
    output logic             md_done
);

    localparam int              CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_busy, r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem, r_quo, r_dvsr, r_orig;
    logic               r_neg_q, r_neg_r, r_dz;

    // Forwarding: select 11 falls back to the register-file value
    always_comb begin
        case (forward_a)
            2'b01:   src_a_ex = result_wb;
            2'b10:   src_a_ex = alu_result_mem;
            default: src_a_ex = rd1_ex;
        endcase
        case (forward_b)
            2'b01:   src_b_ex = result_wb;
            2'b10:   src_b_ex = alu_result_mem;
            default: src_b_ex = rd2_ex;
        endcase
    end

    logic             w_is_mul, w_is_div, w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_is_mul = (md_op_ex == c_OP_MULT) || (md_op_ex == c_OP_MULTU);
    assign w_is_div = (md_op_ex == c_OP_DIV)  || (md_op_ex == c_OP_DIVU);
    assign w_signed = (md_op_ex == c_OP_MULT) || (md_op_ex == c_OP_DIV);
    assign w_a_neg  = w_signed & src_a_ex[WIDTH-1];
    assign w_b_neg  = w_signed & src_b_ex[WIDTH-1];
    assign w_a_mag  = w_a_neg ? ('0 - src_a_ex) : src_a_ex;
    assign w_b_mag  = w_b_neg ? ('0 - src_b_ex) : src_b_ex;

    // Shift-add multiply step
    logic [2*WIDTH-1:0] w_acc_next, w_prod;
    logic               w_mul_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg_q ? ('0 - w_acc_next) : w_acc_next;
`ifdef MD_EARLY_OUT_EN
    assign w_mul_last = (r_cnt == c_LAST) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_mul_last = (r_cnt == c_LAST);
`endif

    // Restoring divide step on a WIDTH+1-bit partial remainder
    logic [WIDTH:0]   w_shifted, w_diff;
    logic [WIDTH-1:0] w_rem_next, w_quo_next, w_q_fix, w_r_fix;
    logic             w_div_last;

    assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_dvsr};
    assign w_rem_next = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_q_fix    = r_neg_q ? ('0 - w_quo_next) : w_quo_next;
    assign w_r_fix    = r_neg_r ? ('0 - w_rem_next) : w_rem_next;
    assign w_div_last = (r_cnt == c_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (md_start_ex && w_is_mul)      w_state_next = MUL;
                else if (md_start_ex && w_is_div) w_state_next = DIV;
            end
            MUL:     if (w_mul_last) w_state_next = IDLE;
            DIV:     if (w_div_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= ((r_state == MUL) && w_mul_last) || ((r_state == DIV) && w_div_last);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_orig   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md_start_ex) begin
                        if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_cnt    <= '0;
                        end else if (w_is_div) begin
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_dvsr  <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_orig  <= src_a_ex;
                            r_dz    <= (src_b_ex == '0);
                            r_cnt   <= '0;
                        end else if (md_op_ex == c_OP_MTHI) begin
                            r_hi <= src_a_ex;
                        end else if (md_op_ex == c_OP_MTLO) begin
                            r_lo <= src_a_ex;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Divide by zero reports the raw dividend, not a sign-fixed one
                    if (w_div_last) begin
                        r_hi <= r_dz ? r_orig : w_r_fix;
                        r_lo <= r_dz ? '1     : w_q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_out  = r_hi;
    assign lo_out  = r_lo;
    assign md_busy = r_busy;
    assign md_done = r_done;

endmodule

`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-stage multiply/divide unit.
- Consumes the forwarding selects produced by the hazard unit and resolves operands A/B from the register-file, MEM-stage or WB-stage values.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, into HI/LO registers; also executes MTHI/MTLO.
- Raises md_busy so pipeline control can stall dependent MFHI/MFLO instructions and any new mul/div operation.

Parameters:
- WIDTH, 32, operand/HI/LO width; also the iteration count per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- forward_a  input  2  operand A select: 00 = rd1_ex, 01 = result_wb, 10 = alu_result_mem, 11 = rd1_ex.
- forward_b  input  2  operand B select; same encoding as forward_a, using rd2_ex.
- rd1_ex  input  WIDTH  register-file read data for rs.
- rd2_ex  input  WIDTH  register-file read data for rt.
- alu_result_mem  input  WIDTH  MEM-stage ALU result.
- result_wb  input  WIDTH  WB-stage result.
- md_start_ex  input  1  valid mul/div-class instruction in EX this cycle.
- md_op_ex  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- src_a_ex  output  WIDTH  forwarded operand A (combinational); also feeds the ALU.
- src_b_ex  output  WIDTH  forwarded operand B (combinational).
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.
- md_busy  output  1  registered; high while an iteration is in progress.
- md_done  output  1  registered one-cycle pulse after HI/LO are written by MULT/DIV.

Behaviour:
- Reset (synchronous): state = IDLE; hi_out, lo_out, md_busy, md_done and iteration counter = 0. Reset applied mid-operation aborts the operation with no HI/LO write.
- Forwarding muxes: purely combinational, zero latency; select 11 behaves as 00.
- FSM states: IDLE, MUL, DIV.
- IDLE + md_start_ex + MULT/MULTU:
  - capture src_a/src_b; go to MUL; counter = 0.
  - Signed ops convert operands to magnitude and record the result sign.
- IDLE + md_start_ex + DIV/DIVU: same capture; go to DIV. Divide is restoring, with a WIDTH+1-bit partial remainder.
- IDLE + MTHI/MTLO: hi_out or lo_out = src_a_ex at that edge. No busy assertion, no md_done.
- Opcode 000/111, or md_start_ex low: no action.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- DIV: one quotient bit per cycle.
- Completion:
  - After WIDTH iterations, apply sign fix-up, write {HI,LO} and return to IDLE.
  - Multiply: HI:LO = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
- Timing for a start in cycle N:
  - md_busy high in cycles N+1..N+WIDTH.
  - HI/LO valid from cycle N+WIDTH+1.
  - md_done high in cycle N+WIDTH+1 only.
  - A new start is accepted in cycle N+WIDTH+1.
- Signed fix-up:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wrap).
- Divide by zero (signed or unsigned): LO = all ones, HI = original dividend. Latency is unchanged.
- Protocol violation: md_start_ex while md_busy is high is ignored, including MTHI/MTLO. The operation in flight is unaffected. Pipeline control must stall such instructions.
- Operands are captured at start. Later changes on forward_*, rd*, result_wb or alu_result_mem do not affect the operation in flight.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: MUL terminates when the remaining unshifted multiplier bits are all zero, checked after each iteration (minimum 1 iteration). md_busy is then high for k cycles, where k is the position of the highest set multiplier magnitude bit plus 1 (k = 1 for a zero multiplier). md_done follows one cycle later. DIV is unchanged.
- Undefined: all multiplies take exactly WIDTH iterations.

Test Plan:
- forward_a = 10, alu_result_mem = 0x1234, rd1_ex = 0x5; forward_b = 01, result_wb = 0x77 -> src_a_ex = 0x1234 and src_b_ex = 0x77 in the same cycle; forward_a = 11 -> src_a_ex = 0x5.
- MULT with A = 0xFFFFFFFE (-2), B = 3, start in cycle N -> md_busy high N+1..N+32; in N+33 HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, md_done = 1 for one cycle. With MD_EARLY_OUT_EN, busy lasts only N+1..N+2.
- DIVU 100 / 7 -> LO = 14, HI = 2. DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 0x55 / 0 -> LO = 0xFFFFFFFF, HI = 0x55, done at N+33.
- MTLO with A = 0xCAFE while idle -> lo_out = 0xCAFE the next cycle, md_busy stays 0. MTHI issued while busy -> ignored; the pending MULT result is written intact.
- rst asserted at cycle N+10 of a DIV -> next cycle md_busy = 0, HI/LO = 0, md_done never pulses; a new start the following cycle completes normally.
